// File: rtl/c_vector_writer.sv
// c_vector_writer: accepts one beat of four 16-bit lane results and
// serialises them into four single-port memory writes, one per cycle.
// Vector k, element e is written at BASE_ADDR + {k[1:0], e[3:0]} (10-bit wrap).
module c_vector_writer #(
  parameter logic [9:0]  BASE_ADDR = 10'h040,
  parameter int unsigned ELEMENTS  = 16
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        en,
  input  logic        c_element_ready,
  input  logic [15:0] c0_element,
  input  logic [15:0] c1_element,
  input  logic [15:0] c2_element,
  input  logic [15:0] c3_element,
  input  logic        last_element,
  output logic        writer_ready,
  output logic [9:0]  memory_address,
  output logic [15:0] memory_write_data,
  output logic        memory_write_enable,
  output logic        vector_done,
  output logic        protocol_error
);

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 10;
  localparam int unsigned IW    = 4;
  localparam int unsigned LANES = 4;
  localparam logic [IW-1:0] LAST_IDX = IW'(ELEMENTS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    W0   = 3'd1,
    W1   = 3'd2,
    W2   = 3'd3,
    W3   = 3'd4,
    DONE = 3'd5
  } state_e;

  state_e                    state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [LANES-1:0][DW-1:0]  hold_q, hold_d;
  logic                      last_q, last_d;
  logic                      perr_q, perr_d;
  logic                      idle_ready;
  logic                      writing;
  logic [1:0]                lane;

  // State, element index, hold registers and sticky error flag
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      last_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      perr_q  <= perr_d;
    end
  end

  // Next-state: accept a beat in IDLE, walk the four lanes, optional DONE
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    last_d     = last_q;
    perr_d     = perr_q;
    idle_ready = (state_q == IDLE) && en;

    // A beat offered while we cannot take it is dropped and flagged
    if (c_element_ready && !idle_ready) begin
      perr_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (idle_ready && c_element_ready) begin
          hold_d  = {c3_element, c2_element, c1_element, c0_element};
          last_d  = last_element;
          state_d = W0;
        end
      end
      W0: if (en) state_d = W1;
      W1: if (en) state_d = W2;
      W2: if (en) state_d = W3;
      W3: begin
        if (en) begin
          idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
          state_d = last_q ? DONE : IDLE;
        end
      end
      DONE: begin
        if (en) begin
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode; clear forces every output low in its own cycle
  always_comb begin
    writer_ready        = 1'b0;
    memory_write_enable = 1'b0;
    memory_address      = '0;
    memory_write_data   = '0;
    vector_done         = 1'b0;
    protocol_error      = 1'b0;
    writing             = 1'b0;
    lane                = 2'd0;

    case (state_q)
      W0: begin writing = 1'b1; lane = 2'd0; end
      W1: begin writing = 1'b1; lane = 2'd1; end
      W2: begin writing = 1'b1; lane = 2'd2; end
      W3: begin writing = 1'b1; lane = 2'd3; end
      default: ;
    endcase

    if (!clear) begin
      writer_ready   = (state_q == IDLE) && en;
      vector_done    = (state_q == DONE) && en;
      protocol_error = perr_q;
      if (writing) begin
        memory_write_enable = en;
        memory_address      = BASE_ADDR + AW'({lane, idx_q});
        memory_write_data   = hold_q[lane];
      end
    end
  end

endmodule

// File: tb/tb_c_vector_writer.sv
// Bench for c_vector_writer: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based write model.
module tb_c_vector_writer;

  localparam logic [9:0]  BASE_A = 10'h040;
  localparam logic [9:0]  BASE_W = 10'h3F8;
  localparam int unsigned ELEMS  = 16;

  logic              clock;
  logic              clear, en, c_element_ready, last_element;
  logic [3:0][15:0]  c_in;

  logic        wr_rdy, we, vdone, perr;
  logic [9:0]  addr;
  logic [15:0] wdata;
  logic        w_wr_rdy, w_we, w_vdone, w_perr;
  logic [9:0]  w_addr;
  logic [15:0] w_wdata;

  c_vector_writer #(.BASE_ADDR(BASE_A), .ELEMENTS(ELEMS)) dut (
    .clock(clock), .clear(clear), .en(en), .c_element_ready(c_element_ready),
    .c0_element(c_in[0]), .c1_element(c_in[1]), .c2_element(c_in[2]),
    .c3_element(c_in[3]), .last_element(last_element),
    .writer_ready(wr_rdy), .memory_address(addr), .memory_write_data(wdata),
    .memory_write_enable(we), .vector_done(vdone), .protocol_error(perr)
  );

  c_vector_writer #(.BASE_ADDR(BASE_W), .ELEMENTS(ELEMS)) dut_w (
    .clock(clock), .clear(clear), .en(en), .c_element_ready(c_element_ready),
    .c0_element(c_in[0]), .c1_element(c_in[1]), .c2_element(c_in[2]),
    .c3_element(c_in[3]), .last_element(last_element),
    .writer_ready(w_wr_rdy), .memory_address(w_addr), .memory_write_data(w_wdata),
    .memory_write_enable(w_we), .vector_done(w_vdone), .protocol_error(w_perr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    bit clr, en, rdy, last;
    logic [15:0] dat;
    bit x_rdy, x_we;
    logic [9:0] x_addr;
    logic [15:0] x_data;
    bit x_done, x_perr;
  } vec_t;

  function automatic vec_t mk(bit clr, bit en_i, bit rdy, bit last, logic [15:0] dat,
                              bit x_rdy, bit x_we, logic [9:0] x_addr,
                              logic [15:0] x_data, bit x_done, bit x_perr);
    vec_t v;
    v.clr = clr; v.en = en_i; v.rdy = rdy; v.last = last; v.dat = dat;
    v.x_rdy = x_rdy; v.x_we = x_we; v.x_addr = x_addr; v.x_data = x_data;
    v.x_done = x_done; v.x_perr = x_perr;
    return v;
  endfunction

  vec_t tbl[21];

  // ---------------- behavioural model: queue of pending writes ----------------
  typedef struct { int lane; int e; logic [15:0] d; } wr_t;
  wr_t m_q[$];
  int  m_e;
  bit  m_done, m_perr;
  int  wr_cnt, done_cnt;
  logic [9:0]  last_wa, last_waw;
  logic [15:0] last_wd;

  function automatic logic [9:0] model_addr(logic [9:0] base, int lane, int e);
    return 10'(int'(base) + 16 * lane + e);
  endfunction

  function automatic bit model_idle();
    return (m_q.size() == 0) && !m_done;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_e = 0; m_done = 1'b0; m_perr = 1'b0;
  endtask

  // One clock: predict, sample at negedge, advance model at posedge
  task automatic step();
    bit x_rdy, x_we, x_done, x_perr, have;
    wr_t f;
    x_rdy = 0; x_we = 0; x_done = 0; x_perr = 0; have = 0;
    f.lane = 0; f.e = 0; f.d = '0;
    if (!clear) begin
      have   = (m_q.size() > 0);
      if (have) f = m_q[0];
      x_rdy  = model_idle() && en;
      x_we   = have && en;
      x_done = !have && m_done && en;
      x_perr = m_perr;
    end
    @(negedge clock);
    chk("writer_ready", 32'(wr_rdy), 32'(x_rdy));
    chk("write_enable", 32'(we), 32'(x_we));
    chk("vector_done", 32'(vdone), 32'(x_done));
    chk("protocol_error", 32'(perr), 32'(x_perr));
    if (have) begin
      chk("address", 32'(addr), 32'(model_addr(BASE_A, f.lane, f.e)));
      chk("write_data", 32'(wdata), 32'(f.d));
      chk("address_wrapbase", 32'(w_addr), 32'(model_addr(BASE_W, f.lane, f.e)));
    end
    if (we) begin
      wr_cnt++;
      last_wa = addr;
      last_wd = wdata;
    end
    if (w_we) last_waw = w_addr;
    if (vdone) done_cnt++;
    @(posedge clock);
    if (clear) begin
      model_reset();
    end else begin
      if (c_element_ready && !x_rdy) m_perr = 1'b1;
      if (en) begin
        if (m_q.size() > 0) begin
          void'(m_q.pop_front());
        end else if (m_done) begin
          m_done = 1'b0;
          m_e = 0;
        end else if (c_element_ready) begin
          for (int n = 0; n < 4; n++) begin
            wr_t w;
            w.lane = n; w.e = m_e; w.d = c_in[n];
            m_q.push_back(w);
          end
          m_e = (m_e + 1) % ELEMS;
          m_done = last_element;
        end
      end
    end
    #1;
  endtask

  // Wait (bounded) until the model can take a beat, then offer one
  task automatic send_beat(input bit last, input logic [15:0] d0, input logic [15:0] d1,
                           input logic [15:0] d2, input logic [15:0] d3);
    int g;
    g = 0;
    en = 1'b1; c_element_ready = 1'b0; clear = 1'b0;
    while (!model_idle()) begin
      step();
      g++;
      if (g > 20) begin
        chk("beat_wait_timeout", 32'(g), 32'(0));
        break;
      end
    end
    c_element_ready = 1'b1; last_element = last;
    c_in[0] = d0; c_in[1] = d1; c_in[2] = d2; c_in[3] = d3;
    step();
    c_element_ready = 1'b0; last_element = 1'b0;
  endtask

  task automatic idle_steps(input int n);
    c_element_ready = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int w0;
    logic [15:0] d3_last;

    clear = 1'b1; en = 1'b1; c_element_ready = 1'b0; last_element = 1'b0;
    c_in = '0;
    wr_cnt = 0; done_cnt = 0; last_wa = '0; last_waw = '0; last_wd = '0;
    model_reset();

    //              clr en rdy last dat      rdy we addr     data      done perr
    tbl[0]  = mk(1, 1, 0, 0, 16'h0000, 0, 0, 10'h000, 16'h0000, 0, 0);
    tbl[1]  = mk(1, 1, 0, 0, 16'h0000, 0, 0, 10'h000, 16'h0000, 0, 0);
    tbl[2]  = mk(1, 1, 0, 0, 16'h0000, 0, 0, 10'h000, 16'h0000, 0, 0);
    tbl[3]  = mk(0, 1, 1, 0, 16'h1111, 1, 0, 10'h000, 16'h0000, 0, 0);
    tbl[4]  = mk(0, 1, 0, 0, 16'h0000, 0, 1, 10'h040, 16'h1111, 0, 0);
    tbl[5]  = mk(0, 1, 0, 0, 16'h0000, 0, 1, 10'h050, 16'h2222, 0, 0);
    tbl[6]  = mk(0, 1, 1, 0, 16'h5555, 0, 1, 10'h060, 16'h3333, 0, 0);
    tbl[7]  = mk(0, 1, 0, 0, 16'h0000, 0, 1, 10'h070, 16'h4444, 0, 1);
    tbl[8]  = mk(0, 1, 0, 0, 16'h0000, 1, 0, 10'h000, 16'h0000, 0, 1);
    tbl[9]  = mk(0, 0, 0, 0, 16'h0000, 0, 0, 10'h000, 16'h0000, 0, 1);
    tbl[10] = mk(0, 1, 1, 1, 16'hA000, 1, 0, 10'h000, 16'h0000, 0, 1);
    tbl[11] = mk(0, 1, 0, 0, 16'h0000, 0, 1, 10'h041, 16'hA000, 0, 1);
    tbl[12] = mk(0, 1, 0, 0, 16'h0000, 0, 1, 10'h051, 16'hB111, 0, 1);
    tbl[13] = mk(0, 1, 0, 0, 16'h0000, 0, 1, 10'h061, 16'hC222, 0, 1);
    tbl[14] = mk(0, 1, 0, 0, 16'h0000, 0, 1, 10'h071, 16'hD333, 0, 1);
    tbl[15] = mk(0, 1, 0, 0, 16'h0000, 0, 0, 10'h000, 16'h0000, 1, 1);
    tbl[16] = mk(0, 1, 0, 0, 16'h0000, 1, 0, 10'h000, 16'h0000, 0, 1);
    tbl[17] = mk(0, 1, 1, 0, 16'h0100, 1, 0, 10'h000, 16'h0000, 0, 1);
    tbl[18] = mk(0, 1, 0, 0, 16'h0000, 0, 1, 10'h040, 16'h0100, 0, 1);
    tbl[19] = mk(1, 1, 0, 0, 16'h0000, 0, 0, 10'h000, 16'h0000, 0, 0);
    tbl[20] = mk(0, 1, 0, 0, 16'h0000, 1, 0, 10'h000, 16'h0000, 0, 0);

    @(posedge clock);
    #1;
    for (int i = 0; i < 21; i++) begin
      clear = tbl[i].clr; en = tbl[i].en;
      c_element_ready = tbl[i].rdy; last_element = tbl[i].last;
      for (int n = 0; n < 4; n++) c_in[n] = tbl[i].dat + 16'(n) * 16'h1111;
      @(negedge clock);
      chk($sformatf("tbl%0d_ready", i), 32'(wr_rdy), 32'(tbl[i].x_rdy));
      chk($sformatf("tbl%0d_we", i), 32'(we), 32'(tbl[i].x_we));
      chk($sformatf("tbl%0d_done", i), 32'(vdone), 32'(tbl[i].x_done));
      chk($sformatf("tbl%0d_perr", i), 32'(perr), 32'(tbl[i].x_perr));
      if (tbl[i].x_we || tbl[i].clr) begin
        chk($sformatf("tbl%0d_addr", i), 32'(addr), 32'(tbl[i].x_addr));
        chk($sformatf("tbl%0d_data", i), 32'(wdata), 32'(tbl[i].x_data));
      end
      @(posedge clock);
      #1;
    end
    clear = 1'b0; en = 1'b1; c_element_ready = 1'b0; last_element = 1'b0;
    model_reset();

    // Full pass: 16 beats, last on beat 15, then the next pass restarts at 0
    done_cnt = 0; w0 = wr_cnt; d3_last = 16'h0;
    for (int b = 0; b < 16; b++) begin
      d3_last = 16'(16'hC300 + b);
      send_beat(b == 15, 16'(16'hC000 + b), 16'(16'hC100 + b), 16'(16'hC200 + b), d3_last);
    end
    idle_steps(6);
    chk("pass_write_count", 32'(wr_cnt - w0), 32'd64);
    chk("pass_last_addr", 32'(last_wa), 32'h07F);
    chk("pass_last_data", 32'(last_wd), 32'(d3_last));
    chk("pass_done_pulses", 32'(done_cnt), 32'd1);
    send_beat(1'b0, 16'hE000, 16'hE001, 16'hE002, 16'hE003);
    idle_steps(1);
    chk("next_pass_first_addr", 32'(last_wa), 32'h040);
    idle_steps(4);

    // Stall three cycles in W1: no strobes, address held, nothing lost
    w0 = wr_cnt;
    send_beat(1'b0, 16'h4A00, 16'h4A01, 16'h4A02, 16'h4A03);
    idle_steps(1);
    en = 1'b0;
    idle_steps(3);
    chk("stall_held_addr", 32'(addr), 32'h051);
    chk("stall_writes_before_resume", 32'(wr_cnt - w0), 32'd1);
    en = 1'b1;
    idle_steps(4);
    chk("stall_total_writes", 32'(wr_cnt - w0), 32'd4);

    // Clear during W2 abandons the beat; next beat lands at element 0
    w0 = wr_cnt; done_cnt = 0;
    send_beat(1'b1, 16'h6000, 16'h6001, 16'h6002, 16'h6003);
    idle_steps(2);
    clear = 1'b1;
    idle_steps(1);
    clear = 1'b0;
    idle_steps(6);
    chk("clear_abandoned_writes", 32'(wr_cnt - w0), 32'd2);
    chk("clear_no_done", 32'(done_cnt), 32'd0);
    send_beat(1'b0, 16'h7000, 16'hBEEF, 16'h7002, 16'h7003);
    idle_steps(2);
    chk("wrap_c1_addr", 32'(last_waw), 32'h008);
    chk("post_clear_c1_addr", 32'(last_wa), 32'h050);
    idle_steps(3);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      clear           = ($urandom_range(0, 99) < 2);
      en              = ($urandom_range(0, 99) < 80);
      c_element_ready = ($urandom_range(0, 99) < 45);
      last_element    = ($urandom_range(0, 99) < 15);
      for (int n = 0; n < 4; n++) c_in[n] = 16'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
